feature_fifo_read_scheduler: RTL and testbench

- Read-side sequencer for the 128-to-8 width-converting feature FIFO.
- Walks a programmed frame of rows, issuing one FIFO read per element, and streams the elements downstream with valid/ready.
- At each row end, issues a single push_bubble so the next row starts on a 16-element (one write word) boundary.
- Sits between the feature FIFO and the convolution input shifter.

---
 rtl/feature_fifo_read_scheduler_if.sv | 41 ++++
 rtl/feature_fifo_read_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_feature_fifo_read_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_fifo_read_scheduler_if.sv
// ---------------------------------------------------------------------------
// feature_fifo_read_scheduler_if
// Bundles the two handshake sides of the feature FIFO read scheduler:
//   - FIFO read side : fifo_empty, fifo_rddata (in), fifo_rden,
//                      fifo_push_bubble, fifo_bubble_num (out)
//   - element stream : o_valid, o_data, o_row_last, o_frame_last (out),
//                      i_ready (in)
// Modports:
//   master : the scheduler's view (drives rden/bubble and the stream)
//   slave  : the environment's view (FIFO plus downstream consumer)
// ---------------------------------------------------------------------------
interface feature_fifo_read_scheduler_if #(
  parameter int DATA_R = 8,
  parameter int LEN_W  = 10
) ();

  logic              fifo_empty;
  logic [DATA_R-1:0] fifo_rddata;
  logic              fifo_rden;
  logic              fifo_push_bubble;
  logic [LEN_W-1:0]  fifo_bubble_num;

  logic              o_valid;
  logic [DATA_R-1:0] o_data;
  logic              o_row_last;
  logic              o_frame_last;
  logic              i_ready;

  modport master (
    input  fifo_empty, fifo_rddata, i_ready,
    output fifo_rden, fifo_push_bubble, fifo_bubble_num,
    output o_valid, o_data, o_row_last, o_frame_last
  );

  modport slave (
    output fifo_empty, fifo_rddata, i_ready,
    input  fifo_rden, fifo_push_bubble, fifo_bubble_num,
    input  o_valid, o_data, o_row_last, o_frame_last
  );

endinterface

// File: rtl/feature_fifo_read_scheduler.sv
// ---------------------------------------------------------------------------
// feature_fifo_read_scheduler
// Read-side sequencer for the 128-to-8 width-converting feature FIFO. Walks a
// programmed frame of rows, issues one FIFO read per element, and streams the
// elements to the convolution input shifter with valid/ready. After every row
// a single push_bubble realigns the FIFO so the next row starts on an
// ALIGN-element write-word boundary.
//
// Ports:
//   system_clk   clock
//   rst          synchronous active-high reset
//   cfg_start    start pulse, honoured only while idle
//   cfg_row_len  elements per row   (latched on start)
//   cfg_row_num  rows per frame     (latched on start)
//   cfg_pad      zero pad per row side (only with FEATURE_SCHED_ZERO_PAD_EN)
//   bus          FIFO read side + output element stream (master modport)
//   o_busy       high from accepted start until o_done
//   o_done       one-cycle pulse once the frame has fully drained
//
// Optional feature: define FEATURE_SCHED_ZERO_PAD_EN to add cfg_pad; each row
// is then emitted as cfg_pad zeros, row_len FIFO elements, cfg_pad zeros.
// ---------------------------------------------------------------------------
module feature_fifo_read_scheduler #(
  parameter int DATA_R = 8,
  parameter int LEN_W  = 10,
  parameter int ALIGN  = 16
) (
  input  logic                      system_clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [LEN_W-1:0]          cfg_row_len,
  input  logic [LEN_W-1:0]          cfg_row_num,
`ifdef FEATURE_SCHED_ZERO_PAD_EN
  input  logic [1:0]                cfg_pad,
`endif
  feature_fifo_read_scheduler_if.master bus,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Position inside a row: leading pad, FIFO body, trailing pad.
  typedef enum logic [1:0] {
    PH_LEAD  = 2'd0,
    PH_BODY  = 2'd1,
    PH_TRAIL = 2'd2
  } phase_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Elements still missing to fill the last write word of a row.
  function automatic logic [LEN_W-1:0] calc_bubble(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] mask;
    mask        = LEN_W'(ALIGN - 1);
    calc_bubble = (LEN_W'(ALIGN) - (len & mask)) & mask;
  endfunction

  // FSM
  state_t state_r;
  state_t state_s;

  // Latched configuration
  logic [LEN_W-1:0] row_len_r;
  logic [LEN_W-1:0] row_num_r;
  logic [LEN_W-1:0] bubble_r;
  logic [1:0]       pad_r;
  logic [1:0]       cfg_pad_s;

  // Walk counters
  logic [LEN_W-1:0] col_r;
  logic [LEN_W-1:0] row_r;
  logic [1:0]       pad_cnt_r;
  phase_t           phase_r;

  // Element issued last cycle, arriving now (FIFO data or a pad zero)
  logic inflight_r;
  logic if_pad_r;
  logic if_row_last_r;
  logic if_frame_last_r;

  // 2-entry skid buffer
  logic [DATA_R-1:0] skid_data_r [0:1];
  logic [1:0]        skid_row_last_r;
  logic [1:0]        skid_frame_last_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        skid_cnt_r;

  logic o_busy_r;
  logic o_done_r;

  // Combinational control
  logic             pop_s;
  logic [2:0]       occ_s;
  logic             room_s;
  logic             col_last_s;
  logic             row_last_idx_s;
  logic             pad_last_s;
  logic             start_ok_s;
  logic             cfg_zero_s;
  logic             drain_done_s;
  logic             rden_s;
  logic             pad_issue_s;
  logic             issue_s;
  logic             row_end_s;
  logic             push_bubble_s;
  logic [LEN_W-1:0] bubble_num_s;

`ifdef FEATURE_SCHED_ZERO_PAD_EN
  assign cfg_pad_s = cfg_pad;
`else
  assign cfg_pad_s = 2'd0;
`endif

  assign pop_s          = (skid_cnt_r != 2'd0) & bus.i_ready;
  // Occupancy as it will be after this cycle's pop and capture; keeping it
  // below 2 before a new issue guarantees the skid never overflows while
  // still allowing one element per cycle with i_ready high.
  assign occ_s          = {1'b0, skid_cnt_r} - {2'b00, pop_s} + {2'b00, inflight_r};
  assign room_s         = (occ_s < 3'd2);
  assign col_last_s     = (col_r == (row_len_r - LEN_ONE));
  assign row_last_idx_s = (row_r == (row_num_r - LEN_ONE));
  assign pad_last_s     = (pad_cnt_r == (pad_r - 2'd1));
  assign start_ok_s     = (state_r == ST_IDLE) & cfg_start;
  assign cfg_zero_s     = (cfg_row_len == LEN_ZERO) | (cfg_row_num == LEN_ZERO);
  assign drain_done_s   = (state_r == ST_DRAIN) & (occ_s == 3'd0);
  assign issue_s        = rden_s | pad_issue_s;

  // FSM state register
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          state_s = cfg_zero_s ? ST_DRAIN : ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (row_end_s) begin
          if (bubble_r != LEN_ZERO) begin
            state_s = ST_BUBBLE;
          end else if (row_last_idx_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      ST_BUBBLE: begin
        // row_r has already wrapped to 0 if the bubble closed the last row
        if (row_r == LEN_ZERO) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: read / pad issue and bubble push
  always_comb begin
    rden_s        = 1'b0;
    pad_issue_s   = 1'b0;
    push_bubble_s = 1'b0;
    bubble_num_s  = LEN_ZERO;
    case (state_r)
      ST_READ: begin
        case (phase_r)
          PH_LEAD, PH_TRAIL: begin
            pad_issue_s = room_s;
          end
          PH_BODY: begin
            rden_s = room_s & ~bus.fifo_empty;
          end
          default: begin
            rden_s      = 1'b0;
            pad_issue_s = 1'b0;
          end
        endcase
      end
      ST_BUBBLE: begin
        push_bubble_s = 1'b1;
        bubble_num_s  = bubble_r;
      end
      default: begin
        rden_s        = 1'b0;
        pad_issue_s   = 1'b0;
        push_bubble_s = 1'b0;
        bubble_num_s  = LEN_ZERO;
      end
    endcase
  end

  // Row end: last body element without padding, or last trailing pad
  always_comb begin
    row_end_s = 1'b0;
    if (rden_s && col_last_s && (pad_r == 2'd0)) begin
      row_end_s = 1'b1;
    end else if (pad_issue_s && (phase_r == PH_TRAIL) && pad_last_s) begin
      row_end_s = 1'b1;
    end else begin
      row_end_s = 1'b0;
    end
  end

  // Configuration latch and row/column walk
  always_ff @(posedge system_clk) begin
    if (rst) begin
      row_len_r <= LEN_ZERO;
      row_num_r <= LEN_ZERO;
      bubble_r  <= LEN_ZERO;
      pad_r     <= 2'd0;
      col_r     <= LEN_ZERO;
      row_r     <= LEN_ZERO;
      pad_cnt_r <= 2'd0;
      phase_r   <= PH_BODY;
    end else if (start_ok_s) begin
      row_len_r <= cfg_row_len;
      row_num_r <= cfg_row_num;
      bubble_r  <= calc_bubble(cfg_row_len);
      pad_r     <= cfg_pad_s;
      col_r     <= LEN_ZERO;
      row_r     <= LEN_ZERO;
      pad_cnt_r <= 2'd0;
      phase_r   <= (cfg_pad_s != 2'd0) ? PH_LEAD : PH_BODY;
    end else if (issue_s) begin
      case (phase_r)
        PH_LEAD: begin
          if (pad_last_s) begin
            pad_cnt_r <= 2'd0;
            phase_r   <= PH_BODY;
          end else begin
            pad_cnt_r <= pad_cnt_r + 2'd1;
          end
        end
        PH_BODY: begin
          if (col_last_s) begin
            col_r <= LEN_ZERO;
            if (pad_r != 2'd0) begin
              phase_r <= PH_TRAIL;
            end
          end else begin
            col_r <= col_r + LEN_ONE;
          end
        end
        PH_TRAIL: begin
          if (pad_last_s) begin
            pad_cnt_r <= 2'd0;
          end else begin
            pad_cnt_r <= pad_cnt_r + 2'd1;
          end
        end
        default: begin
          phase_r <= PH_BODY;
        end
      endcase
      // Later assignment wins: a finished row restarts at its leading pad.
      if (row_end_s) begin
        row_r   <= row_last_idx_s ? LEN_ZERO : (row_r + LEN_ONE);
        phase_r <= (pad_r != 2'd0) ? PH_LEAD : PH_BODY;
      end
    end
  end

  // In-flight tag stage: tags travel alongside the FIFO's one-cycle read latency
  always_ff @(posedge system_clk) begin
    if (rst) begin
      inflight_r      <= 1'b0;
      if_pad_r        <= 1'b0;
      if_row_last_r   <= 1'b0;
      if_frame_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      if_pad_r        <= pad_issue_s;
      if_row_last_r   <= row_end_s;
      if_frame_last_r <= row_end_s & row_last_idx_s;
    end
  end

  // Skid buffer: capture arriving element, pop on accepted handshake
  always_ff @(posedge system_clk) begin
    if (rst) begin
      skid_data_r[0]    <= {DATA_R{1'b0}};
      skid_data_r[1]    <= {DATA_R{1'b0}};
      skid_row_last_r   <= 2'b00;
      skid_frame_last_r <= 2'b00;
      wr_ptr_r          <= 1'b0;
      rd_ptr_r          <= 1'b0;
      skid_cnt_r        <= 2'd0;
    end else begin
      if (inflight_r) begin
        skid_data_r[wr_ptr_r]       <= if_pad_r ? {DATA_R{1'b0}} : bus.fifo_rddata;
        skid_row_last_r[wr_ptr_r]   <= if_row_last_r;
        skid_frame_last_r[wr_ptr_r] <= if_frame_last_r;
        wr_ptr_r                    <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      skid_cnt_r <= skid_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  // Busy/done status
  always_ff @(posedge system_clk) begin
    if (rst) begin
      o_busy_r <= 1'b0;
      o_done_r <= 1'b0;
    end else begin
      o_done_r <= drain_done_s;
      if (start_ok_s) begin
        o_busy_r <= 1'b1;
      end else if (drain_done_s) begin
        o_busy_r <= 1'b0;
      end
    end
  end

  assign bus.fifo_rden        = rden_s;
  assign bus.fifo_push_bubble = push_bubble_s;
  assign bus.fifo_bubble_num  = bubble_num_s;
  assign bus.o_valid          = (skid_cnt_r != 2'd0);
  assign bus.o_data           = skid_data_r[rd_ptr_r];
  assign bus.o_row_last       = skid_row_last_r[rd_ptr_r];
  assign bus.o_frame_last     = skid_frame_last_r[rd_ptr_r];
  assign o_busy               = o_busy_r;
  assign o_done               = o_done_r;

endmodule

// File: tb/tb_feature_fifo_read_scheduler.sv
module tb_feature_fifo_read_scheduler;

  localparam int DATA_R = 8;
  localparam int LEN_W  = 10;
  localparam int ALIGN  = 16;

  logic system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  logic             rst;
  logic             cfg_start;
  logic [LEN_W-1:0] cfg_row_len;
  logic [LEN_W-1:0] cfg_row_num;
`ifdef FEATURE_SCHED_ZERO_PAD_EN
  logic [1:0]       cfg_pad;
`endif
  logic             o_busy;
  logic             o_done;

  feature_fifo_read_scheduler_if #(.DATA_R(DATA_R), .LEN_W(LEN_W)) bus ();

  feature_fifo_read_scheduler #(.DATA_R(DATA_R), .LEN_W(LEN_W), .ALIGN(ALIGN)) dut (
    .system_clk (system_clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_row_len(cfg_row_len),
    .cfg_row_num(cfg_row_num),
`ifdef FEATURE_SCHED_ZERO_PAD_EN
    .cfg_pad    (cfg_pad),
`endif
    .bus        (bus),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // FIFO model: element i holds value i; a bubble skips bubble_num elements.
  logic [DATA_R-1:0] fifo_mem [0:1023];
  int   rd_ptr = 0;
  logic fifo_clear;
  logic force_empty;

  assign bus.fifo_empty = force_empty | (rd_ptr >= 1024);

  always @(posedge system_clk) begin
    if (fifo_clear) begin
      rd_ptr          <= 0;
      bus.fifo_rddata <= '0;
    end else if (bus.fifo_rden) begin
      bus.fifo_rddata <= fifo_mem[rd_ptr[9:0]];
      rd_ptr          <= rd_ptr + 1;
    end else if (bus.fifo_push_bubble) begin
      rd_ptr <= rd_ptr + int'(bus.fifo_bubble_num);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int row_len;
    int row_num;
    int pad;
    int ready_mode;   // 0: always ready, 1: pattern 1,0,0,1
    int gap_after;    // element index after whose read the FIFO goes empty for 5 cycles, -1 none
    int exp_elems;
    int exp_rden;
    int exp_bubbles;
    int exp_bubble_num;
    int stride;       // FIFO elements between row starts
    int exp_span;     // cycles from first to last rden, -1 unchecked
    int exp_resume;   // cycle of the first read after the gap, -1 unchecked
  } vec_t;

  vec_t vecs[$];

  task automatic reset_and_clear();
    rst         = 1'b1;
    fifo_clear  = 1'b1;
    cfg_start   = 1'b0;
    cfg_row_len = '0;
    cfg_row_num = '0;
`ifdef FEATURE_SCHED_ZERO_PAD_EN
    cfg_pad     = 2'd0;
`endif
    bus.i_ready = 1'b1;
    force_empty = 1'b0;
    repeat (2) @(posedge system_clk);
    #1;
    rst        = 1'b0;
    fifo_clear = 1'b0;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rden_n = 0, pops = 0, bub_n = 0, viol = 0;
    int first_rden = -1, last_rden = -1, last_pop = -1, done_cyc = -1;
    int resume_cyc = -1, gap_left = 0;
    int r = 0, c = 0, row_w, expd;
    bit done_seen = 0;
    bit prev_stall = 0;
    logic [DATA_R-1:0] prev_data = '0;
    logic prev_rl = 1'b0, prev_fl = 1'b0;

    row_w       = v.row_len + 2 * v.pad;
    cfg_row_len = LEN_W'(v.row_len);
    cfg_row_num = LEN_W'(v.row_num);
`ifdef FEATURE_SCHED_ZERO_PAD_EN
    cfg_pad     = 2'(v.pad);
`endif
    cfg_start   = 1'b1;
    @(posedge system_clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      #1;
      cfg_start   = (cyc == 2);   // must be ignored: not idle
      bus.i_ready = (v.ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      force_empty = (gap_left > 0);
      if (gap_left > 0) gap_left--;
      #1;
      if (cyc == 0) check($sformatf("v%0d_busy_start", idx), int'(o_busy), 1);
      if (bus.fifo_rden) begin
        if (bus.fifo_empty) viol++;
        if (bus.fifo_push_bubble) viol++;
        if (rden_n == 0) first_rden = cyc;
        last_rden = cyc;
        if (v.gap_after >= 0 && rden_n == v.gap_after + 1) resume_cyc = cyc;
        rden_n++;
        if (v.gap_after >= 0 && rden_n == v.gap_after + 1) gap_left = 5;
      end
      if (bus.fifo_push_bubble) begin
        bub_n++;
        check($sformatf("v%0d_bubble_num", idx), int'(bus.fifo_bubble_num), v.exp_bubble_num);
      end else if (bus.fifo_bubble_num != '0) begin
        viol++;
      end
      if (prev_stall) begin
        check($sformatf("v%0d_hold_valid", idx), int'(bus.o_valid), 1);
        check($sformatf("v%0d_hold_data", idx), int'(bus.o_data), int'(prev_data));
        check($sformatf("v%0d_hold_tags", idx), int'({bus.o_row_last, bus.o_frame_last}),
              int'({prev_rl, prev_fl}));
      end
      if (bus.o_valid && bus.i_ready) begin
        expd = (c < v.pad || c >= v.pad + v.row_len) ? 0 : (r * v.stride + c - v.pad) % 256;
        check($sformatf("v%0d_data_e%0d", idx, pops), int'(bus.o_data), expd);
        check($sformatf("v%0d_row_last_e%0d", idx, pops), int'(bus.o_row_last),
              int'(c == row_w - 1));
        check($sformatf("v%0d_frame_last_e%0d", idx, pops), int'(bus.o_frame_last),
              int'(c == row_w - 1 && r == v.row_num - 1));
        pops++;
        last_pop = cyc;
        if (c == row_w - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      if (rden_n - pops > 2) viol++;
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      prev_rl    = bus.o_row_last;
      prev_fl    = bus.o_frame_last;
      if (o_done) begin
        done_seen = 1;
        done_cyc  = cyc;
        break;
      end
      @(posedge system_clk);
    end
    cfg_start = 1'b0;
    check($sformatf("v%0d_done_seen", idx), int'(done_seen), 1);
    check($sformatf("v%0d_elements", idx), pops, v.exp_elems);
    check($sformatf("v%0d_rden_count", idx), rden_n, v.exp_rden);
    check($sformatf("v%0d_bubble_count", idx), bub_n, v.exp_bubbles);
    check($sformatf("v%0d_protocol_violations", idx), viol, 0);
    check($sformatf("v%0d_done_after_last_pop", idx), done_cyc - last_pop, 1);
    if (v.exp_span >= 0)
      check($sformatf("v%0d_rden_span", idx), last_rden - first_rden, v.exp_span);
    if (v.exp_resume >= 0)
      check($sformatf("v%0d_resume_cycle", idx), resume_cyc, v.exp_resume);
    @(posedge system_clk);
    #2;
    check($sformatf("v%0d_done_pulse", idx), int'(o_done), 0);
    check($sformatf("v%0d_busy_after", idx), int'(o_busy), 0);
    check($sformatf("v%0d_valid_after", idx), int'(bus.o_valid), 0);
  endtask

  int done_at;
  int rden_seen;
  int busy_seen;

  initial begin
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 8'(i);

    //          len num pad rdy gap elems rden bubs bnum stride span resume
    vecs.push_back('{16, 2, 0, 0, -1, 32, 32, 0,  0, 16, 31, -1});
    vecs.push_back('{10, 3, 0, 0, -1, 30, 30, 3,  6, 16, 31, -1});
    vecs.push_back('{16, 1, 0, 1, -1, 16, 16, 0,  0, 16, -1, -1});
    vecs.push_back('{16, 1, 0, 0,  7, 16, 16, 0,  0, 16, -1, 13});
    vecs.push_back('{17, 2, 0, 1, -1, 34, 34, 2, 15, 32, -1, -1});
    vecs.push_back('{ 1, 2, 0, 0, -1,  2,  2, 2, 15, 16,  2, -1});
`ifdef FEATURE_SCHED_ZERO_PAD_EN
    vecs.push_back('{ 4, 2, 1, 0, -1, 12,  8, 2, 12, 16, 10, -1});
`endif

    reset_and_clear();
    check("reset_valid", int'(bus.o_valid), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_rden", int'(bus.fifo_rden), 0);
    check("reset_push_bubble", int'(bus.fifo_push_bubble), 0);
    check("reset_bubble_num", int'(bus.fifo_bubble_num), 0);
    check("reset_data", int'(bus.o_data), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_and_clear();
      run_vec(vecs[i], i);
    end

    // Zero row count and zero row length: done two cycles after start, no reads
    for (int k = 0; k < 2; k++) begin
      reset_and_clear();
      cfg_row_len = (k == 0) ? LEN_W'(5) : LEN_W'(0);
      cfg_row_num = (k == 0) ? LEN_W'(0) : LEN_W'(3);
      cfg_start   = 1'b1;
      done_at     = -1;
      rden_seen   = 0;
      busy_seen   = 0;
      for (int i = 1; i <= 4; i++) begin
        @(posedge system_clk);
        #1;
        cfg_start = 1'b0;
        #1;
        if (o_done && done_at < 0) done_at = i;
        if (bus.fifo_rden) rden_seen++;
        if (i == 1) busy_seen = int'(o_busy);
      end
      check($sformatf("degen%0d_done_cycle", k), done_at, 2);
      check($sformatf("degen%0d_rden", k), rden_seen, 0);
      check($sformatf("degen%0d_busy", k), busy_seen, 1);
    end

    // Reset mid-row aborts the frame; a fresh start then runs normally
    reset_and_clear();
    cfg_row_len = LEN_W'(16);
    cfg_row_num = LEN_W'(2);
    cfg_start   = 1'b1;
    bus.i_ready = 1'b0;
    @(posedge system_clk);
    #2;
    cfg_start = 1'b0;
    for (int k = 0; k < 20 && !bus.o_valid; k++) begin
      @(posedge system_clk);
      #2;
    end
    check("abort_valid_before", int'(bus.o_valid), 1);
    rst        = 1'b1;
    fifo_clear = 1'b1;
    @(posedge system_clk);
    #2;
    check("abort_valid", int'(bus.o_valid), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_rden", int'(bus.fifo_rden), 0);
    check("abort_push_bubble", int'(bus.fifo_push_bubble), 0);
    rst         = 1'b0;
    fifo_clear  = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge system_clk);
    #2;
    check("abort_idle_rden", int'(bus.fifo_rden), 0);
    run_vec(vecs[0], 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
